// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK  = 2'd1,
    YIELD = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam int DEF_MAX_WAIT = 4;
  localparam int DEF_LOCK_MAX = 8;

  // Bits needed to hold a counter that runs from 0 up to max_val inclusive
  function automatic int ctr_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_sat_ctr.sv
// rtl/dmem_arb_sat_ctr.sv - saturating up-counter with clear and done flag
module dmem_arb_sat_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX = DEF_MAX_WAIT,
  parameter int W   = ctr_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_done
);

  localparam logic [W-1:0] L_MAX = W'(MAX);

  logic [W-1:0] r_cnt;

  // Clear wins over increment; increments stop once the ceiling is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != L_MAX)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = (r_cnt == L_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/DMA arbiter in front of the single-port data memory
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          dma_req_valid,
  output logic          dma_req_ready,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_lock,
  output logic          dma_rsp_valid,
  output logic [DW-1:0] dma_rsp_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int WW = ctr_width(MAX_WAIT);
  localparam int LW = ctr_width(LOCK_MAX);

  arb_state_t    r_state;
  arb_state_t    w_next_state;
  owner_t        w_owner;
  logic          w_accept;
  logic          w_wait_done;
  logic          w_lock_hit;
  logic [LW-1:0] w_lock_cnt;
  logic [WW-1:0] w_unused_wait_cnt;
  logic          w_unused_lock_done;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;

  // Starvation guard: counts cycles a pending DMA request has lost
  dmem_arb_sat_ctr #(.MAX(MAX_WAIT), .W(WW)) u_wait_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (dma_req_valid & ~w_accept),
    .i_clr  (~dma_req_valid | w_accept),
    .o_cnt  (w_unused_wait_cnt),
    .o_done (w_wait_done)
  );

  // Consecutive locked beats; zero whenever the arbiter is not in LOCK
  dmem_arb_sat_ctr #(.MAX(LOCK_MAX), .W(LW)) u_lock_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_accept & dma_lock),
    .i_clr  (w_next_state != LOCK),
    .o_cnt  (w_lock_cnt),
    .o_done (w_unused_lock_done)
  );

  // The beat being accepted now is the one that fills the lock budget
  assign w_lock_hit = (w_lock_cnt == LW'(LOCK_MAX - 1));
  assign w_accept   = (w_owner == OWN_DMA);

  // Arbitration state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Owner selection and next-state logic; nobody owns the memory during reset
  always_comb begin
    w_owner      = OWN_NONE;
    w_next_state = r_state;
    case (r_state)
      ARB: begin
        if (dma_req_valid && (!core_req || w_wait_done)) begin
          w_owner = OWN_DMA;
        end else if (core_req) begin
          w_owner = OWN_CORE;
        end
        if (dma_req_valid && (!core_req || w_wait_done) && dma_lock) begin
          w_next_state = w_lock_hit ? YIELD : LOCK;
        end
      end
      LOCK: begin
        if (dma_req_valid) begin
          w_owner = OWN_DMA;
        end
        if (!dma_req_valid || !dma_lock) begin
          w_next_state = ARB;
        end else if (w_lock_hit) begin
          w_next_state = YIELD;
        end
      end
      YIELD: begin
        if (core_req) begin
          w_owner = OWN_CORE;
        end
        w_next_state = ARB;
      end
      default: begin
        w_next_state = ARB;
      end
    endcase
    if (rst) begin
      w_owner = OWN_NONE;
    end
  end

  // Memory port mux; idle port drives zeros
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (w_owner)
      OWN_CORE: begin
        mem_we    = core_we;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end
      OWN_DMA: begin
        mem_we    = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // DMA read response: data captured at the acceptance edge, no back-pressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_accept & ~dma_we;
      if (w_accept && !dma_we) begin
        r_rsp_rdata <= mem_rdata;
      end
    end
  end

  assign dma_req_ready = w_accept;
  assign core_stall    = core_req & (w_owner != OWN_CORE) & ~rst;
  assign core_rdata    = (w_owner == OWN_CORE) ? mem_rdata : '0;
  assign dma_rsp_valid = r_rsp_valid;
  assign dma_rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;
  localparam int LOCK_MAX = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          core_stall;
  logic          dma_req_valid;
  logic          dma_req_ready;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_lock;
  logic          dma_rsp_valid;
  logic [DW-1:0] dma_rsp_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem_arr [64];
  logic [DW-1:0] ref_mem [64];

  int            m_wait;
  int            m_beats;
  bit            m_yield;
  bit            m_rsp_valid;
  logic [DW-1:0] m_rsp_data;

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .core_req      (core_req),
    .core_we       (core_we),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_rdata    (core_rdata),
    .core_stall    (core_stall),
    .dma_req_valid (dma_req_valid),
    .dma_req_ready (dma_req_ready),
    .dma_we        (dma_we),
    .dma_addr      (dma_addr),
    .dma_wdata     (dma_wdata),
    .dma_lock      (dma_lock),
    .dma_rsp_valid (dma_rsp_valid),
    .dma_rsp_rdata (dma_rsp_rdata),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory seen by the DUT
  assign mem_rdata = mem_arr[mem_addr[5:0]];
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr[5:0]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait      = 0;
    m_beats     = 0;
    m_yield     = 0;
    m_rsp_valid = 0;
    m_rsp_data  = '0;
  endtask

  // Who should own the memory this cycle: 0 nobody, 1 core, 2 DMA
  function automatic int exp_owner(input bit creq, input bit dv);
    if (m_yield) return creq ? 1 : 0;
    if (m_beats > 0) return dv ? 2 : 0;
    if (dv && (!creq || m_wait >= MAX_WAIT)) return 2;
    return creq ? 1 : 0;
  endfunction

  task automatic step(input bit creq, input bit cwe, input logic [31:0] caddr,
                      input logic [31:0] cwd, input bit dv, input bit dwe,
                      input logic [31:0] daddr, input logic [31:0] dwd, input bit dlk);
    int          own;
    logic [31:0] ea, ew;
    bit          ewe;
    core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
    dma_req_valid = dv; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd; dma_lock = dlk;
    #1;
    own = exp_owner(creq, dv);
    ea = '0; ew = '0; ewe = 0;
    if (own == 1) begin ea = caddr; ew = cwd; ewe = cwe; end
    if (own == 2) begin ea = daddr; ew = dwd; ewe = dwe; end
    chk("dma_req_ready", dma_req_ready, own == 2);
    chk("core_stall", core_stall, creq && own != 1);
    chk("mem_we", mem_we, ewe);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ew);
    chk("core_rdata", core_rdata, (own == 1) ? ref_mem[caddr[5:0]] : 32'h0);
    @(posedge clk);
    m_rsp_valid = (own == 2) && !dwe;
    if (m_rsp_valid) m_rsp_data = ref_mem[daddr[5:0]];
    if (ewe) ref_mem[ea[5:0]] = ew;
    if (dv && own != 2) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
    else m_wait = 0;
    if (m_yield) begin
      m_yield = 0; m_beats = 0;
    end else if (own == 2 && dlk) begin
      m_beats++;
      if (m_beats >= LOCK_MAX) begin m_yield = 1; m_beats = 0; end
    end else begin
      m_beats = 0;
    end
    #1;
    chk("dma_rsp_valid", dma_rsp_valid, m_rsp_valid);
    chk("dma_rsp_rdata", dma_rsp_rdata, m_rsp_data);
  endtask

  task automatic do_reset();
    rst = 1; core_req = 1; core_we = 1; core_addr = 32'h4; core_wdata = 32'h1;
    dma_req_valid = 1; dma_we = 1; dma_addr = 32'h8; dma_wdata = 32'h2; dma_lock = 1;
    #1;
    chk("rst_ready", dma_req_ready, 1'b0);
    chk("rst_stall", core_stall, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", dma_rsp_valid, 1'b0);
    chk("rst_rsp_rdata", dma_rsp_rdata, 32'h0);
    rst = 0;
    model_reset();
  endtask

  initial begin
    logic [31:0] ra, rb;
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[16] = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    model_reset();
    do_reset();

    // Core-only load, same-cycle data
    step(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    // DMA write then read back through the response register
    step(0, 0, 0, 0, 1, 1, 32'h20, 32'h55, 0);
    step(0, 0, 0, 0, 1, 0, 32'h20, 0, 0);
    chk("dma_readback_55", dma_rsp_rdata, 32'h55);

    // Continuous contention: DMA forced in every MAX_WAIT+1 cycles
    for (int i = 0; i < 15; i++) begin
      ra = $urandom % 64; rb = $urandom % 64;
      step(1, 0, ra, 0, 1, 0, rb, 0, 0);
    end

    // Locked burst against constant core traffic
    for (int i = 0; i < 22; i++) begin
      ra = $urandom % 64; rb = $urandom % 64;
      step(1, 0, ra, 0, 1, i[0], rb, $urandom, 1);
    end

    // Lock dropped on the third beat, then the core wins
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'h3, 0, 1);
    step(0, 0, 0, 0, 1, 0, 32'h4, 0, 1);
    step(0, 0, 0, 0, 1, 0, 32'h5, 0, 0);
    step(1, 0, 32'h6, 0, 1, 0, 32'h7, 0, 1);

    // Reset lands on the acceptance edge of a DMA read
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    core_req = 0; dma_req_valid = 1; dma_we = 0; dma_addr = 32'h9; dma_lock = 0;
    #1;
    chk("midrst_ready_pre", dma_req_ready, 1'b1);
    rst = 1;
    #1;
    chk("midrst_ready", dma_req_ready, 1'b0);
    chk("midrst_mem_we", mem_we, 1'b0);
    @(posedge clk);
    #1;
    chk("midrst_rsp_valid", dma_rsp_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    step(1, 0, 32'hA, 0, 1, 0, 32'hB, 0, 0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 4) != 0, ($urandom % 3) == 0, $urandom % 64, $urandom,
           ($urandom % 2) == 0, ($urandom % 3) == 0, $urandom % 64, $urandom,
           ($urandom % 10) < 7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the pipeline MEM stage and a DMA/debug loader port. The core has default priority, and the DMA is guaranteed service through a starvation counter. A DMA lock gives the loader back-to-back bursts, capped so the core always makes progress. The block sits between the EX/MEM pipeline register and the data memory, and it feeds a stall request into the hazard unit.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_WAIT, 4, cycles a pending DMA request may lose to the core before it is force-granted (≥1)
- LOCK_MAX, 8, maximum consecutive locked DMA beats before a forced core slot (≥1)

Ports (one clock `clk`; reset `rst` is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- core_req  in  1  MEM stage wants memory this cycle (load or MemWriteM)
- core_we  in  1  core write
- core_addr  in  AW  ALUresultM
- core_wdata  in  DW  WriteDataM
- core_rdata  out  DW  read data, valid in the same cycle when not stalled
- core_stall  out  1  core lost arbitration; hazard unit holds F/D/E/M and bubbles W
- dma_req_valid  in  1  DMA request
- dma_req_ready  out  1  DMA granted; transfer when valid & ready
- dma_we  in  1  DMA write
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_lock  in  1  hold grant for the following beats
- dma_rsp_valid  out  1  read response strobe
- dma_rsp_rdata  out  DW  registered read data
- mem_we  out  1  to DataMemory MemWrite
- mem_addr  out  AW  to DataMemory Address
- mem_wdata  out  DW  to DataMemory Write_data
- mem_rdata  in  DW  combinational read data from DataMemory

## Operation
- States:
  - ARB: normal arbitration.
  - LOCK: DMA owns the memory.
  - YIELD: one cycle in which the core has absolute priority.
- Owner is chosen combinationally each cycle. The mem_* outputs mux the owner's signals; with no owner, mem_we=0 and addr/wdata=0.
- ARB owner selection:
  - DMA owns if dma_req_valid & (!core_req | wait_cnt==MAX_WAIT).
  - Otherwise the core owns if core_req.
- LOCK: DMA owns while dma_req_valid. The core is stalled whenever core_req is high.
- YIELD: core owns if core_req. The DMA is never granted.
- dma_req_ready=1 exactly when the DMA owns. core_stall = core_req & !core owns.
- wait_cnt behaviour:
  - Increments, saturating at MAX_WAIT, on dma_req_valid & !dma_req_ready.
  - Clears on any DMA grant, or when dma_req_valid=0.
- Transitions:
  - ARB→LOCK on an accepted beat with dma_lock=1; lock_cnt is set to 1.
  - LOCK: each accepted beat with dma_lock=1 increments lock_cnt.
  - LOCK→ARB when an accepted beat has dma_lock=0, or when dma_req_valid=0.
  - LOCK→YIELD when lock_cnt reaches LOCK_MAX on an accepted beat with dma_lock=1.
  - YIELD→ARB unconditionally after one cycle. If dma_lock is still high, LOCK may be re-entered.
- Reads: for an accepted DMA read, dma_rsp_rdata<=mem_rdata and dma_rsp_valid<=1 on the next edge. DMA writes produce no response.
- Core reads: core_rdata=mem_rdata whenever the core owns. Otherwise core_rdata=0.

## Timing
- Reset values:
  - state=ARB, wait_cnt=0, lock_cnt=0, dma_rsp_valid=0, dma_rsp_rdata=0.
  - While rst is high: dma_req_ready=0, core_stall=0, mem_we=0.
- Latency:
  - Core access: 0 cycles.
  - DMA read data: 1 cycle after acceptance. Responses arrive in order and cannot back-pressure.
  - DMA write: commits at the acceptance edge.
- Worst-case DMA wait against continuous core traffic: MAX_WAIT cycles, with the grant on cycle MAX_WAIT+1.
- Worst-case core stall in locked mode: LOCK_MAX cycles.
- Reset mid-burst: the pending response is dropped (dma_rsp_valid cleared) and the state returns to ARB.
- No requesters: no memory activity. The counters hold their reset-consistent values.

## Structure
- Package dmem_arb_pkg holds:
  - typedef arb_state_t {ARB, LOCK, YIELD}
  - owner_t {OWN_NONE, OWN_CORE, OWN_DMA}
  - default MAX_WAIT and LOCK_MAX localparams
- Sub-module dmem_arb_sat_ctr is a parameterised saturating counter with inc, clr and a done flag. It is instantiated twice: once for wait_cnt and once for lock_cnt.
- Top level contains the FSM, owner mux and response register.

## Test plan
- Core-only load at addr 0x10, memory word 0xDEADBEEF → core_rdata=0xDEADBEEF in the same cycle; core_stall=0; dma_req_ready=0.
- DMA write 0x55 to 0x20 with core idle → ready=1 in the same cycle; mem_we=1; a subsequent DMA read of 0x20 gives dma_rsp_valid one cycle later with rdata=0x55.
- Continuous core_req and continuous DMA valid, MAX_WAIT=4 → core owns cycles 1-4; DMA is granted on cycle 5 with core_stall=1; the pattern repeats every 5 cycles.
- dma_lock held high, LOCK_MAX=8, core_req constant → 8 DMA beats with core_stall=1, then one YIELD cycle where the core owns, then DMA resumes.
- Lock dropped on beat 3 → return to ARB; the core wins the next cycle.
- rst asserted the cycle after a DMA read is accepted → dma_rsp_valid stays 0; state=ARB; no mem_we during reset.
